// File: rtl/lab3_converter_state_diagram.sv
// rtl/lab3_converter_state_diagram.sv - bit-serial Excess-3 to BCD converter (Mealy FSM)
module lab3_converter_state_diagram (
  input  logic Clk,
  input  logic Rst,
  input  logic X,
  output logic Z
);

  // The state records the bit position in the frame and the pending borrow of (X - 0011).
  typedef enum logic [2:0] {
    S0 = 3'd0,  // bit0
    S1 = 3'd1,  // bit1, no borrow
    S2 = 3'd2,  // bit1, borrow
    S3 = 3'd3,  // bit2, no borrow
    S4 = 3'd4,  // bit2, borrow
    S5 = 3'd5,  // bit3, no borrow
    S6 = 3'd6   // bit3, borrow
  } state_t;

  state_t state, state_next;
  logic   z_fsm;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S0;
    z_fsm      = 1'b0;
    case (state)
      S0: begin
        state_next = X ? S1 : S2;
        z_fsm      = ~X;
      end
      S1: begin
        state_next = X ? S3 : S4;
        z_fsm      = ~X;
      end
      S2: begin
        state_next = S4;
        z_fsm      = X;
      end
      S3: begin
        state_next = S5;
        z_fsm      = X;
      end
      S4: begin
        state_next = X ? S5 : S6;
        z_fsm      = ~X;
      end
      S5: begin
        state_next = S0;
        z_fsm      = X;
      end
      S6: begin
        state_next = S0;
        z_fsm      = ~X;
      end
      // The unused encoding falls back to frame start with a quiet output.
      default: begin
        state_next = S0;
        z_fsm      = 1'b0;
      end
    endcase
  end

  assign Z = Rst & z_fsm;

endmodule

// File: tb/tb_lab3_converter_state_diagram.sv
// tb/tb_lab3_converter_state_diagram.sv - directed and random checks of the Excess-3 to BCD converter
module tb_lab3_converter_state_diagram;

  logic Clk;
  logic Rst;
  logic X;
  logic Z;

  int n_cmp;
  int n_err;

  lab3_converter_state_diagram dut (
    .Clk(Clk),
    .Rst(Rst),
    .X  (X),
    .Z  (Z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enters just after a rising edge; drives one frame LSB first and captures Z at each falling edge.
  task automatic send_digit(input logic [3:0] d, output logic [3:0] z);
    for (int i = 0; i < 4; i++) begin
      X = d[i];
      @(negedge Clk);
      z[i] = Z;
      @(posedge Clk);
      #1;
    end
  endtask

  logic [3:0] vin  [13];
  logic [3:0] vexp [13];
  logic [3:0] zf;
  logic [3:0] d;

  initial begin
    n_cmp = 0;
    n_err = 0;
    Rst = 1'b0;
    X   = 1'b0;

    // Reset held: Z stays low for either X value across clock edges.
    for (int i = 0; i < 4; i++) begin
      X = i[0];
      @(negedge Clk);
      check("reset_z", {31'd0, Z}, 32'd0);
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;

    send_digit(4'b0011, zf);
    check("after_reset_0011", {28'd0, zf}, 32'h0);

    // Valid sweep plus invalid codes, hand-computed.
    vin[0]  = 4'b0011; vexp[0]  = 4'b0000;
    vin[1]  = 4'b0100; vexp[1]  = 4'b0001;
    vin[2]  = 4'b0101; vexp[2]  = 4'b0010;
    vin[3]  = 4'b0110; vexp[3]  = 4'b0011;
    vin[4]  = 4'b0111; vexp[4]  = 4'b0100;
    vin[5]  = 4'b1000; vexp[5]  = 4'b0101;
    vin[6]  = 4'b1001; vexp[6]  = 4'b0110;
    vin[7]  = 4'b1010; vexp[7]  = 4'b0111;
    vin[8]  = 4'b1011; vexp[8]  = 4'b1000;
    vin[9]  = 4'b1100; vexp[9]  = 4'b1001;
    vin[10] = 4'b0000; vexp[10] = 4'b1101;
    vin[11] = 4'b0010; vexp[11] = 4'b1111;
    vin[12] = 4'b1111; vexp[12] = 4'b1100;
    for (int i = 0; i < 13; i++) begin
      send_digit(vin[i], zf);
      check($sformatf("vector_%b", vin[i]), {28'd0, zf}, {28'd0, vexp[i]});
    end

    // Mealy behaviour: in S0, Z tracks ~X without a clock edge.
    X = 1'b0;
    #1;
    check("mealy_s0_x0", {31'd0, Z}, 32'd1);
    X = 1'b1;
    #1;
    check("mealy_s0_x1", {31'd0, Z}, 32'd0);
    send_digit(4'b0101, zf);
    check("mealy_followup_0101", {28'd0, zf}, 32'h2);

    // Abort a 1010 frame after two bits with an asynchronous reset pulse.
    X = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    #1;
    X = 1'b1;
    @(negedge Clk);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check("midframe_reset_z", {31'd0, Z}, 32'd0);
    Rst = 1'b1;
    send_digit(4'b0110, zf);
    check("after_midframe_0110", {28'd0, zf}, 32'h3);

    // Random valid digits, back to back.
    for (int i = 0; i < 300; i++) begin
      d = 4'($urandom_range(12, 3));
      send_digit(d, zf);
      check($sformatf("random_%0d_%b", i, d), {28'd0, zf}, {28'd0, d - 4'd3});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
